// File: rtl/seg_decode_rx.sv
`default_nettype none
// ============================================================================
// Module      : seg_decode_rx
// Description : Receives two 7-segment digit patterns (tens, then ones) over a
//               valid/ready input handshake. It decodes them to a binary value
//               in the range 0..99 and presents that value on a valid/ready
//               output handshake.
//               An accepted pattern that is not a legal digit produces a
//               one-cycle err pulse and returns the receiver to the
//               tens-digit state.
// Ports       : clk          - sole clock, rising edge
//               rst          - synchronous active-high reset
//               seg_in[6:0]  - segment pattern, bit order gfedcba (bit0 = a)
//               seg_valid    - seg_in carries a pattern this cycle
//               seg_ready    - receiver accepts seg_in this cycle
//               value[6:0]   - decoded value 0..99, kept until overwritten
//               value_valid  - value pending, held until taken
//               value_ready  - consumer takes value
//               err          - one-cycle pulse after an illegal accepted pattern
//               err_count    - saturating count of err pulses (only when
//                              SEG_DECODE_ERRCNT_EN is defined)
// Options     : SEG_DECODE_ERRCNT_EN - adds the err_count port and counter
// Revision    : 1.0 - initial release
// ============================================================================
module seg_decode_rx (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_in,
    input  logic       seg_valid,
    output logic       seg_ready,
    output logic [6:0] value,
    output logic       value_valid,
    input  logic       value_ready,
    output logic       err
`ifdef SEG_DECODE_ERRCNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    typedef enum logic [1:0] {
        ST_TENS = 2'd0,
        ST_ONES = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t     r_state;
    logic [3:0] r_tens;
    logic [6:0] r_value;
    logic       r_value_valid;
    logic       r_seg_ready;
    logic       r_err;

    logic       w_legal;
    logic [3:0] w_digit;
    logic       w_xfer;
    logic       w_take;
    logic       w_err_set;
    logic [6:0] w_sum;

    // Pattern decoder: anything outside the ten digit shapes is illegal.
    always_comb begin
        w_legal = 1'b1;
        w_digit = 4'd0;
        case (seg_in)
            7'b0111111: w_digit = 4'd0;
            7'b0000110: w_digit = 4'd1;
            7'b1011011: w_digit = 4'd2;
            7'b1001111: w_digit = 4'd3;
            7'b1100110: w_digit = 4'd4;
            7'b1101101: w_digit = 4'd5;
            7'b1111101: w_digit = 4'd6;
            7'b0000111: w_digit = 4'd7;
            7'b1111111: w_digit = 4'd8;
            7'b1101111: w_digit = 4'd9;
            default: begin
                w_legal = 1'b0;
                w_digit = 4'd0;
            end
        endcase
    end

    // seg_ready is only high in TENS/ONES, so an accepted illegal pattern
    // always maps to an err pulse regardless of which digit was expected.
    assign w_xfer    = seg_valid & r_seg_ready;
    assign w_take    = r_value_valid & value_ready;
    assign w_err_set = w_xfer & ~w_legal;
    assign w_sum     = ({3'b000, r_tens} * 7'd10) + {3'b000, w_digit};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_TENS;
            r_tens        <= 4'd0;
            r_value       <= 7'd0;
            r_value_valid <= 1'b0;
            r_seg_ready   <= 1'b1;
            r_err         <= 1'b0;
        end else begin
            r_err <= w_err_set;
            case (r_state)
                ST_TENS: begin
                    if (w_xfer && w_legal) begin
                        r_tens  <= w_digit;
                        r_state <= ST_ONES;
                    end
                end
                ST_ONES: begin
                    if (w_xfer) begin
                        if (w_legal) begin
                            r_value       <= w_sum;
                            r_value_valid <= 1'b1;
                            r_seg_ready   <= 1'b0;
                            r_state       <= ST_HOLD;
                        end else begin
                            // Illegal ones digit abandons the partial number.
                            r_tens  <= 4'd0;
                            r_state <= ST_TENS;
                        end
                    end
                end
                ST_HOLD: begin
                    // seg_ready reopens one cycle after the take: no
                    // same-cycle pass-through of a new digit.
                    if (w_take) begin
                        r_value_valid <= 1'b0;
                        r_seg_ready   <= 1'b1;
                        r_state       <= ST_TENS;
                    end
                end
                default: begin
                    r_value_valid <= 1'b0;
                    r_seg_ready   <= 1'b1;
                    r_state       <= ST_TENS;
                end
            endcase
        end
    end

    assign seg_ready   = r_seg_ready;
    assign value       = r_value;
    assign value_valid = r_value_valid;
    assign err         = r_err;

`ifdef SEG_DECODE_ERRCNT_EN
    logic [7:0] r_err_count;

    // Counts on the same edge that raises err; sticks at 255.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_count <= 8'd0;
        end else if (w_err_set && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign err_count = r_err_count;
`endif

endmodule
`default_nettype wire

// File: doc/seg_decode_rx.md
SEG_DECODE_RX -- requirements
Module: seg_decode_rx

Interface
REQ-001 Parameters: none.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 seg_in  input  7  segment pattern, bit order gfedcba, active-high (bit0 = a).
REQ-005 seg_valid  input  1  seg_in holds a digit pattern this cycle.
REQ-006 seg_ready  output  1  block accepts seg_in this cycle; transfer = seg_valid & seg_ready.
REQ-007 value  output  7  decoded binary value, 0..99.
REQ-008 value_valid  output  1  value is held and stable until taken.
REQ-009 value_ready  input  1  consumer takes value; take = value_valid & value_ready.
REQ-010 err  output  1  one-cycle pulse: an accepted pattern was not a legal digit.
REQ-011 err_count  output  8  saturating count of err pulses; present only with SEG_DECODE_ERRCNT_EN.

Function
REQ-012 The block SHALL decode these patterns (all others illegal): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
REQ-013 The FSM SHALL have states TENS (await tens digit), ONES (await ones digit) and HOLD (result pending).
REQ-014 In TENS and ONES, seg_ready SHALL be 1; in HOLD, seg_ready SHALL be 0.
REQ-015 TENS: on a legal transfer, register the digit as tens and go to ONES; on an illegal transfer, pulse err and stay in TENS.
REQ-016 ONES: on a legal transfer, register value = tens*10 + ones in 7 bits and go to HOLD; on an illegal transfer, pulse err, discard tens, and go to TENS.
REQ-017 value_valid SHALL be 1 exactly while in HOLD, starting the cycle after the ones transfer (latency 1 clock).
REQ-018 value SHALL remain stable while value_valid=1 and value_ready=0.
REQ-019 HOLD: on take, go to TENS; seg_ready becomes 1 in the following cycle, so there is no same-cycle pass-through.
REQ-020 Without a transfer, state SHALL NOT change; seg_in SHALL be ignored when seg_valid=0.
REQ-021 err SHALL be registered and asserted for the single cycle after the illegal transfer.
REQ-022 value SHALL keep its last result after leaving HOLD until the next result is written.

Reset
REQ-023 rst=1 SHALL force state TENS, value=0, value_valid=0, err=0, tens=0 and err_count=0, overriding any concurrent transfer or take.
REQ-024 Reset asserted in ONES or HOLD SHALL discard the partial or pending result without an err pulse.
REQ-025 In the cycle after rst deasserts, seg_ready SHALL be 1.

Configuration
REQ-026 Macro SEG_DECODE_ERRCNT_EN defined: err_count SHALL increment by 1 on each err pulse and saturate at 255; only reset clears it.
REQ-027 Macro undefined: the err_count port and its counter SHALL be absent; all other behaviour is identical.

Verification
REQ-028 Reset, then transfer 1001111 followed by 1101101 -> after 1 cycle, value_valid=1, value=35, seg_ready=0.
REQ-029 Hold value_ready=0 for 5 cycles with seg_valid=1 -> value stays 35, no seg_in is accepted; then value_ready=1 for 1 cycle -> TENS, seg_ready=1 next cycle.
REQ-030 Transfer 1101111, 1101111 -> value=99; transfer 0111111, 0111111 -> value=0.
REQ-031 Transfer 1011011 then illegal 0000001 -> err pulses once, state TENS; then 0000110, 0000110 -> value=11.
REQ-032 Transfer 1100110, then assert rst -> value_valid=0, value=0, err=0, seg_ready=1 the cycle after release.
REQ-033 With SEG_DECODE_ERRCNT_EN, apply 300 illegal transfers in TENS -> err_count=255, state TENS.
